// File: rtl/multi_rename_if.sv
// Rename-unit bundle: rename group, writeback tags, commit lanes, recovery.
// The rename unit is the slave; the front end / ROB side is the master.
interface multi_rename_if #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 80,
  parameter int REN_W    = 2,
  parameter int CMT_W    = 2,
  parameter int WB_W     = 2
);
  localparam int AW = $clog2(NUM_AREG);
  localparam int PW = $clog2(NUM_PREG);
  localparam int CW = $clog2(NUM_PREG - NUM_AREG + 1);

  logic [REN_W-1:0]    ren_valid;
  logic [REN_W-1:0]    ren_alloc;
  logic [REN_W*AW-1:0] ren_rs1;
  logic [REN_W*AW-1:0] ren_rs2;
  logic [REN_W*AW-1:0] ren_rd;
  logic                ren_ready;
  logic [REN_W*PW-1:0] ren_prs1;
  logic [REN_W*PW-1:0] ren_prs2;
  logic [REN_W-1:0]    ren_prs1_rdy;
  logic [REN_W-1:0]    ren_prs2_rdy;
  logic [REN_W*PW-1:0] ren_prd_new;
  logic [REN_W*PW-1:0] ren_prd_old;
  logic [WB_W-1:0]     wb_valid;
  logic [WB_W*PW-1:0]  wb_prd;
  logic [CMT_W-1:0]    cmt_valid;
  logic [CMT_W-1:0]    cmt_alloc;
  logic [CMT_W*AW-1:0] cmt_ard;
  logic [CMT_W*PW-1:0] cmt_prd_new;
  logic [CMT_W*PW-1:0] cmt_prd_old;
  logic                flush;
  logic [CW-1:0]       free_count;

  modport master (
    output ren_valid, ren_alloc, ren_rs1, ren_rs2, ren_rd,
    output wb_valid, wb_prd,
    output cmt_valid, cmt_alloc, cmt_ard, cmt_prd_new, cmt_prd_old,
    output flush,
    input  ren_ready, ren_prs1, ren_prs2, ren_prs1_rdy, ren_prs2_rdy,
    input  ren_prd_new, ren_prd_old, free_count
  );

  modport slave (
    input  ren_valid, ren_alloc, ren_rs1, ren_rs2, ren_rd,
    input  wb_valid, wb_prd,
    input  cmt_valid, cmt_alloc, cmt_ard, cmt_prd_new, cmt_prd_old,
    input  flush,
    output ren_ready, ren_prs1, ren_prs2, ren_prs1_rdy, ren_prs2_rdy,
    output ren_prd_new, ren_prd_old, free_count
  );
endinterface

// File: rtl/multi_rename.sv
// Multi-lane register rename: speculative and committed RATs, circular
// free list with committed head for flush recovery, physical ready table.
module multi_rename #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 80,
  parameter int REN_W    = 2,
  parameter int CMT_W    = 2,
  parameter int WB_W     = 2
) (
  input  logic          clk,
  input  logic          rst,
  multi_rename_if.slave bus
);
  localparam int AW   = $clog2(NUM_AREG);
  localparam int PW   = $clog2(NUM_PREG);
  localparam int FL_D = NUM_PREG - NUM_AREG;
  localparam int CW   = $clog2(FL_D + 1);
  localparam int FW   = $clog2(FL_D);

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [FW-1:0] fptr_t;

  preg_t rat_q [NUM_AREG];
  preg_t rat_d [NUM_AREG];
  preg_t cmt_q [NUM_AREG];
  preg_t cmt_d [NUM_AREG];
  preg_t fl_q  [FL_D];
  preg_t fl_d  [FL_D];
  logic [NUM_PREG-1:0] rdy_q, rdy_d;
  fptr_t head_q, head_d;
  fptr_t tail_q, tail_d;
  fptr_t chead_q, chead_d;
  cnt_t  cnt_q, cnt_d;

  logic [REN_W-1:0] need;
  preg_t prd_new [REN_W];
  cnt_t  need_n, ret_n;
  logic  acc;

  function automatic fptr_t ptr_add(fptr_t p, cnt_t k);
    int s;
    s = int'(p) + int'(k);
    if (s >= FL_D) s = s - FL_D;
    return fptr_t'(s);
  endfunction

  always_comb begin
    need   = '0;
    need_n = '0;
    for (int j = 0; j < REN_W; j++) begin
      prd_new[j] = '0;
      need[j] = bus.ren_valid[j] & bus.ren_alloc[j]
              & (bus.ren_rd[j*AW +: AW] != '0);
      if (need[j]) begin
        prd_new[j] = fl_q[ptr_add(head_q, need_n)];
        need_n     = need_n + cnt_t'(1);
      end
    end
  end

  assign bus.ren_ready  = !rst && !bus.flush && (cnt_q >= need_n);
  assign acc            = bus.ren_ready;
  assign bus.free_count = cnt_q;

  // Source/old-rd lookup: newest older lane in the group beats the RAT
  always_comb begin
    areg_t a;
    preg_t p;
    logic  byp, r;
    bus.ren_prs1     = '0;
    bus.ren_prs2     = '0;
    bus.ren_prs1_rdy = '0;
    bus.ren_prs2_rdy = '0;
    bus.ren_prd_old  = '0;
    bus.ren_prd_new  = '0;
    a   = '0;
    p   = '0;
    byp = 1'b0;
    r   = 1'b0;
    for (int j = 0; j < REN_W; j++) begin
      bus.ren_prd_new[j*PW +: PW] = prd_new[j];
      for (int s = 0; s < 3; s++) begin
        if (s == 0)      a = bus.ren_rs1[j*AW +: AW];
        else if (s == 1) a = bus.ren_rs2[j*AW +: AW];
        else             a = bus.ren_rd[j*AW +: AW];
        p   = rat_q[a];
        byp = 1'b0;
        for (int i = 0; i < j; i++) begin
          if (need[i] && bus.ren_rd[i*AW +: AW] == a) begin
            p   = prd_new[i];
            byp = 1'b1;
          end
        end
        r = rdy_q[p];
        for (int k = 0; k < WB_W; k++)
          if (bus.wb_valid[k] && bus.wb_prd[k*PW +: PW] == p) r = 1'b1;
        if (byp) r = 1'b0;
        if (a == '0) begin
          p = '0;
          r = 1'b1;
        end
        if (s == 0) begin
          bus.ren_prs1[j*PW +: PW] = p;
          bus.ren_prs1_rdy[j]      = r;
        end else if (s == 1) begin
          bus.ren_prs2[j*PW +: PW] = p;
          bus.ren_prs2_rdy[j]      = r;
        end else begin
          bus.ren_prd_old[j*PW +: PW] = p;
        end
      end
    end
  end

  always_comb begin
    areg_t ard;
    rat_d   = rat_q;
    cmt_d   = cmt_q;
    fl_d    = fl_q;
    rdy_d   = rdy_q;
    head_d  = head_q;
    ret_n   = '0;
    ard     = '0;
    if (acc) begin
      for (int j = 0; j < REN_W; j++) begin
        if (need[j]) begin
          rat_d[bus.ren_rd[j*AW +: AW]] = prd_new[j];
          rdy_d[prd_new[j]]             = 1'b0;
        end
      end
      head_d = ptr_add(head_q, need_n);
    end
    for (int k = 0; k < WB_W; k++)
      if (bus.wb_valid[k] && bus.wb_prd[k*PW +: PW] != '0)
        rdy_d[bus.wb_prd[k*PW +: PW]] = 1'b1;
    for (int c = 0; c < CMT_W; c++) begin
      ard = bus.cmt_ard[c*AW +: AW];
      if (bus.cmt_valid[c] && bus.cmt_alloc[c] && ard != '0) begin
        fl_d[ptr_add(tail_q, ret_n)] = bus.cmt_prd_old[c*PW +: PW];
        cmt_d[ard] = bus.cmt_prd_new[c*PW +: PW];
        ret_n = ret_n + cnt_t'(1);
      end
    end
    tail_d  = ptr_add(tail_q, ret_n);
    chead_d = ptr_add(chead_q, ret_n);
    cnt_d   = cnt_q + ret_n - (acc ? need_n : cnt_t'(0));
    // Committed state always holds exactly NUM_AREG pregs, so the list is full
    if (bus.flush) begin
      rat_d  = cmt_d;
      head_d = chead_d;
      rdy_d  = '1;
      cnt_d  = cnt_t'(FL_D);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat_q[i] <= preg_t'(i);
        cmt_q[i] <= preg_t'(i);
      end
      for (int k = 0; k < FL_D; k++)
        fl_q[k] <= preg_t'(NUM_AREG + k);
      rdy_q   <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      chead_q <= '0;
      cnt_q   <= cnt_t'(FL_D);
    end else begin
      rat_q   <= rat_d;
      cmt_q   <= cmt_d;
      fl_q    <= fl_d;
      rdy_q   <= rdy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      chead_q <= chead_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (int'(cnt_q) + int'(ret_n)
              - (acc ? int'(need_n) : 0) <= FL_D)
        else $error("multi_rename: commit returns overflow free list");
  end
endmodule

// File: tb/tb_multi_rename.sv
// Directed and random checks of multi_rename against a queue-based
// sequential rename model.
module tb_multi_rename;
  localparam int AW = 6;
  localparam int PW = 7;
  localparam int NA = 64;
  localparam int NP = 80;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_rename_if bus ();
  multi_rename dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  bit r_v[2], r_a[2];
  int r_rs1[2], r_rs2[2], r_rd[2];
  bit w_v[2];
  int w_p[2];
  bit c_v[2], c_a[2];
  int c_ard[2], c_new[2], c_old[2];
  bit fl_in;

  int o_new[2], o_p1[2], o_p2[2], o_old[2];
  int o_r1[2], o_r2[2];
  int o_rdy, o_fc;

  int rat[NA];
  int cmtm[NA];
  bit prdy[NP];
  int fl[$];
  int infl[$];
  typedef struct { int ard; int pn; int po; } rob_t;
  rob_t rob[$];
  int retq[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    for (int j = 0; j < 2; j++) begin
      r_v[j] = 0; r_a[j] = 0;
      r_rs1[j] = 0; r_rs2[j] = 0; r_rd[j] = 0;
      w_v[j] = 0; w_p[j] = 0;
      c_v[j] = 0; c_a[j] = 0;
      c_ard[j] = 0; c_new[j] = 0; c_old[j] = 0;
    end
    fl_in = 0;
  endtask

  task automatic drive();
    for (int j = 0; j < 2; j++) begin
      bus.ren_valid[j] = r_v[j];
      bus.ren_alloc[j] = r_a[j];
      bus.ren_rs1[j*AW +: AW] = AW'(r_rs1[j]);
      bus.ren_rs2[j*AW +: AW] = AW'(r_rs2[j]);
      bus.ren_rd[j*AW +: AW]  = AW'(r_rd[j]);
      bus.wb_valid[j] = w_v[j];
      bus.wb_prd[j*PW +: PW] = PW'(w_p[j]);
      bus.cmt_valid[j] = c_v[j];
      bus.cmt_alloc[j] = c_a[j];
      bus.cmt_ard[j*AW +: AW]     = AW'(c_ard[j]);
      bus.cmt_prd_new[j*PW +: PW] = PW'(c_new[j]);
      bus.cmt_prd_old[j*PW +: PW] = PW'(c_old[j]);
    end
    bus.flush = fl_in;
  endtask

  task automatic sample();
    for (int j = 0; j < 2; j++) begin
      o_new[j] = int'(bus.ren_prd_new[j*PW +: PW]);
      o_old[j] = int'(bus.ren_prd_old[j*PW +: PW]);
      o_p1[j]  = int'(bus.ren_prs1[j*PW +: PW]);
      o_p2[j]  = int'(bus.ren_prs2[j*PW +: PW]);
      o_r1[j]  = int'(bus.ren_prs1_rdy[j]);
      o_r2[j]  = int'(bus.ren_prs2_rdy[j]);
    end
    o_rdy = int'(bus.ren_ready);
    o_fc  = int'(bus.free_count);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      rat[i]  = i;
      cmtm[i] = i;
    end
    for (int p = 0; p < NP; p++) prdy[p] = 1;
    fl.delete(); infl.delete(); rob.delete();
    for (int k = 0; k < FD; k++) fl.push_back(NA + k);
  endtask

  function automatic bit wbhit(int p);
    for (int k = 0; k < 2; k++)
      if (w_v[k] && w_p[k] == p) return 1;
    return 0;
  endfunction

  task automatic set_commit(input int n);
    rob_t e;
    for (int c = 0; c < n; c++) begin
      if (rob.size() > 0) begin
        e = rob.pop_front();
        c_v[c] = 1; c_a[c] = 1;
        c_ard[c] = e.ard; c_new[c] = e.pn; c_old[c] = e.po;
      end
    end
  endtask

  // Reset while a flush, a rename and a writeback are all being driven
  task automatic busy_reset();
    idle();
    r_v = '{1, 1}; r_a = '{1, 1}; r_rd = '{3, 4};
    fl_in = 1; w_v[0] = 1; w_p[0] = 70;
    drive();
    rst = 1'b1;
    #1;
    chk("rst_ready", int'(bus.ren_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(); drive(); model_reset();
    chk("rst_free", int'(bus.free_count), FD);
  endtask

  task automatic step();
    int wr[NA];
    bit fresh[NA];
    int e_new[2], e_p1[2], e_p2[2], e_old[2];
    int e_r1[2], e_r2[2];
    int need, idx;
    bit ok, nd;
    need = 0;
    for (int j = 0; j < 2; j++)
      if (r_v[j] && r_a[j] && r_rd[j] != 0) need++;
    ok = !fl_in && fl.size() >= need;
    wr = rat;
    for (int i = 0; i < NA; i++) fresh[i] = 0;
    idx = 0;
    for (int j = 0; j < 2; j++) begin
      e_p1[j] = wr[r_rs1[j]];
      e_r1[j] = fresh[r_rs1[j]] ? 0 : int'(prdy[e_p1[j]] | wbhit(e_p1[j]));
      e_p2[j] = wr[r_rs2[j]];
      e_r2[j] = fresh[r_rs2[j]] ? 0 : int'(prdy[e_p2[j]] | wbhit(e_p2[j]));
      e_old[j] = wr[r_rd[j]];
      e_new[j] = 0;
      nd = r_v[j] && r_a[j] && r_rd[j] != 0;
      if (nd && idx < fl.size()) begin
        e_new[j] = fl[idx];
        idx++;
        wr[r_rd[j]] = e_new[j];
        fresh[r_rd[j]] = 1;
      end
    end
    drive();
    #1;
    sample();
    chk("ren_ready", o_rdy, int'(ok));
    chk("free_count", o_fc, fl.size());
    if (ok) begin
      for (int j = 0; j < 2; j++) begin
        chk("prd_new", o_new[j], e_new[j]);
        if (r_v[j]) begin
          chk("prs1", o_p1[j], e_p1[j]);
          chk("prs1_rdy", o_r1[j], e_r1[j]);
          chk("prs2", o_p2[j], e_p2[j]);
          chk("prs2_rdy", o_r2[j], e_r2[j]);
          chk("prd_old", o_old[j], e_old[j]);
        end
      end
    end
    @(posedge clk); #1;
    if (ok) begin
      for (int j = 0; j < 2; j++) begin
        if (r_v[j] && r_a[j] && r_rd[j] != 0) begin
          void'(fl.pop_front());
          infl.push_back(e_new[j]);
          prdy[e_new[j]] = 0;
          rob.push_back('{ard: r_rd[j], pn: e_new[j], po: e_old[j]});
        end
      end
      rat = wr;
    end
    for (int k = 0; k < 2; k++)
      if (w_v[k] && w_p[k] != 0) prdy[w_p[k]] = 1;
    for (int c = 0; c < 2; c++) begin
      if (c_v[c] && c_a[c] && c_ard[c] != 0) begin
        fl.push_back(c_old[c]);
        cmtm[c_ard[c]] = c_new[c];
        void'(infl.pop_front());
      end
    end
    if (fl_in) begin
      rat = cmtm;
      fl = {infl, fl};
      infl.delete();
      rob.delete();
      for (int p = 0; p < NP; p++) prdy[p] = 1;
    end
  endtask

  initial begin
    idle();
    drive();
    busy_reset();

    // writeback hit in the same cycle as a source read
    idle(); r_v[0] = 1; r_a[0] = 1; r_rd[0] = 5; step();
    chk("wb_alloc", o_new[0], 64);
    idle(); r_v[0] = 1; r_rs1[0] = 5; step();
    chk("wb_pre_rdy", o_r1[0], 0);
    idle(); r_v[0] = 1; r_rs1[0] = 5; w_v[1] = 1; w_p[1] = 64; step();
    chk("wb_same_rdy", o_r1[0], 1);
    idle(); r_v[0] = 1; r_rs1[0] = 5; step();
    chk("wb_next_rdy", o_r1[0], 1);

    // intra-group bypass on the same rd
    busy_reset();
    idle();
    r_v = '{1, 1}; r_a = '{1, 1}; r_rd = '{5, 5};
    r_rs1[1] = 5; r_rs2[1] = 7;
    step();
    chk("byp_new0", o_new[0], 64);
    chk("byp_new1", o_new[1], 65);
    chk("byp_prs1", o_p1[1], 64);
    chk("byp_rdy1", o_r1[1], 0);
    chk("byp_old1", o_old[1], 64);
    chk("byp_fc", int'(bus.free_count), 14);
    idle(); r_v[0] = 1; r_rs1[0] = 5; step();
    chk("byp_rat5", o_p1[0], 65);

    // exhaust the free list
    busy_reset();
    for (int n = 0; n < 8; n++) begin
      idle();
      r_v = '{1, 1}; r_a = '{1, 1};
      r_rd[0] = 1 + $urandom_range(0, 62);
      r_rd[1] = 1 + $urandom_range(0, 62);
      step();
    end
    chk("full_fc0", int'(bus.free_count), 0);
    idle(); r_v[0] = 1; r_a[0] = 1; r_rd[0] = 9; step();
    chk("full_need1", o_rdy, 0);
    idle(); r_v = '{1, 1}; r_a[1] = 1; r_rd = '{9, 0}; step();
    chk("full_need0", o_rdy, 1);

    // commit one of three then flush
    busy_reset();
    idle(); r_v = '{1, 1}; r_a = '{1, 1}; r_rd = '{1, 2}; step();
    idle(); r_v[0] = 1; r_a[0] = 1; r_rd[0] = 3; step();
    idle(); set_commit(1); step();
    idle(); fl_in = 1; step();
    idle();
    r_v = '{1, 1}; r_a[0] = 1; r_rd[0] = 9;
    r_rs1 = '{1, 3}; r_rs2[0] = 2;
    step();
    chk("fl_rat1", o_p1[0], 64);
    chk("fl_rat2", o_p2[0], 2);
    chk("fl_rat3", o_p1[1], 3);
    chk("fl_fc", o_fc, 16);
    chk("fl_next", o_new[0], 65);

    // alloc/commit pairs wrapping the list
    busy_reset();
    retq.delete();
    for (int n = 0; n < 40; n++) begin
      idle(); r_v[0] = 1; r_a[0] = 1; r_rd[0] = 1 + $urandom_range(0, 62);
      step();
      if (n >= FD) chk("wrap_new", o_new[0], retq.pop_front());
      idle();
      retq.push_back(rob[0].po);
      set_commit(1);
      step();
      chk("wrap_fc", int'(bus.free_count), FD);
    end

    // random traffic
    busy_reset();
    for (int n = 0; n < 500; n++) begin
      idle();
      for (int j = 0; j < 2; j++) begin
        r_v[j]   = $urandom_range(0, 3) != 0;
        r_a[j]   = $urandom_range(0, 3) != 0;
        r_rs1[j] = $urandom_range(0, 7);
        r_rs2[j] = $urandom_range(0, 7);
        r_rd[j]  = $urandom_range(0, 7);
        w_v[j]   = $urandom_range(0, 1) != 0;
        w_p[j]   = $urandom_range(0, NP - 1);
      end
      set_commit($urandom_range(0, 2));
      fl_in = $urandom_range(0, 31) == 0;
      step();
    end

    // reset colliding with flush and rename restores the initial map
    idle(); r_v[0] = 1; r_a[0] = 1; r_rd[0] = 5; step();
    busy_reset();
    idle();
    r_v[0] = 1; r_a[0] = 1; r_rs1[0] = 5; r_rs2[0] = 9; r_rd[0] = 5;
    step();
    chk("post_prs1", o_p1[0], 5);
    chk("post_rdy1", o_r1[0], 1);
    chk("post_prs2", o_p2[0], 9);
    chk("post_new", o_new[0], 64);
    chk("post_old", o_old[0], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
